vector_bitcount_unit: RTL

Parametrised successor of the vector population count / parity functional unit for the Cray X-MP CPU. It streams a whole vector, VL elements long, from one selected vector register through a STAGES-deep chunked pipeline. Per element it produces the population count, the parity or the leading-zero count. Each result carries a valid strobe and element index, and the run ends with a done pulse, so the vector result write-back path consumes results directly instead of inferring timing from busy.

---
 rtl/vector_fu_pkg.sv | 21 ++
 rtl/bitcount_stage.sv | 81 ++++++++
 rtl/vector_bitcount_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/vector_fu_pkg.sv
// Shared definitions for the vector functional units: mode encodings,
// the count-width helper and the default element-index type.
package vector_fu_pkg;

    typedef enum logic [1:0] {
        MODE_POP    = 2'b00,
        MODE_PARITY = 2'b01,
        MODE_LZC    = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    localparam int DEFAULT_VL_W = 7;

    typedef logic [DEFAULT_VL_W-1:0] elem_idx_t;

    // Bits needed to hold any count from 0 up to and including width.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bitcount_stage.sv
// One pipeline stage of the bit-count unit: folds one chunk of the element
// into the running count and registers the result with its valid/index tag.
module bitcount_stage
    import vector_fu_pkg::*;
#(
    parameter int CHUNK = 16,
    parameter int CW    = 7,
    parameter int VL_W  = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CHUNK-1:0] chunk_i,
    input  logic [CW-1:0]   count_i,
    input  logic            seen_i,
    input  logic            valid_i,
    input  logic [VL_W-1:0] idx_i,
    input  mode_e           mode_i,
    output logic [CW-1:0]   count_o,
    output logic            seen_o,
    output logic            valid_o,
    output logic [VL_W-1:0] idx_o
);

    logic [CW-1:0]   ones;
    logic [CW-1:0]   lzc;
    logic            found;
    logic [CW-1:0]   count_d;
    logic            seen_d;
    logic [CW-1:0]   count_q;
    logic            seen_q;
    logic            valid_q;
    logic [VL_W-1:0] idx_q;

    always_comb begin
        ones  = '0;
        lzc   = '0;
        found = 1'b0;
        for (int b = CHUNK - 1; b >= 0; b--) begin
            ones = ones + CW'(chunk_i[b]);
            if (chunk_i[b]) begin
                found = 1'b1;
            end else if (!found) begin
                lzc = lzc + CW'(1);
            end
        end
    end

    // Once a one has been seen in an earlier chunk, later chunks add no leading zeros.
    always_comb begin
        count_d = count_i;
        seen_d  = seen_i;
        if (mode_i == MODE_LZC) begin
            if (!seen_i) begin
                count_d = count_i + lzc;
                seen_d  = (chunk_i != '0);
            end
        end else begin
            count_d = count_i + ones;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            seen_q  <= 1'b0;
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            count_q <= count_d;
            seen_q  <= seen_d;
            valid_q <= valid_i;
            idx_q   <= idx_i;
        end
    end

    assign count_o = count_q;
    assign seen_o  = seen_q;
    assign valid_o = valid_q;
    assign idx_o   = idx_q;

endmodule

// File: rtl/vector_bitcount_unit.sv
// Vector pop-count / parity / leading-zero-count unit: streams VL elements of
// one vector register through a STAGES-deep chunked pipeline.
module vector_bitcount_unit
    import vector_fu_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int NREG   = 8,
    parameter int VL_W   = 7,
    parameter int STAGES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_start,
    input  logic [1:0]                 i_mode,
    input  logic [$clog2(NREG)-1:0]    i_j,
    input  logic [VL_W-1:0]            i_vl,
    input  logic [NREG*WIDTH-1:0]      i_vdata,
    output logic [WIDTH-1:0]           o_result,
    output logic                       o_valid,
    output logic [VL_W-1:0]            o_elem_idx,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int C  = WIDTH / STAGES;
    localparam int CW = count_width(WIDTH);
    localparam int JW = $clog2(NREG);

    logic            busy_q,    busy_d;
    logic            issuing_q, issuing_d;
    logic [VL_W-1:0] cnt_q,     cnt_d;
    logic [VL_W-1:0] vl_q,      vl_d;
    logic [JW-1:0]   j_q,       j_d;
    mode_e           mode_q,    mode_d;
    logic            in_valid_q;
    logic [VL_W-1:0] in_idx_q;

    logic [WIDTH-1:0] data_pipe  [STAGES];
    logic [CW-1:0]    cnt_pipe   [STAGES+1];
    logic             seen_pipe  [STAGES+1];
    logic             valid_pipe [STAGES+1];
    logic [VL_W-1:0]  idx_pipe   [STAGES+1];

    logic             accept;
    logic             done;
    logic [WIDTH-1:0] sel_data;

    assign accept   = i_start && !busy_q;
    assign sel_data = i_vdata[j_q*WIDTH +: WIDTH];

    // A zero-length run finishes in its first busy cycle; otherwise done
    // coincides with the last element leaving the pipeline.
    assign done = busy_q && ((vl_q == '0) ||
                  (valid_pipe[STAGES] && (idx_pipe[STAGES] == vl_q - VL_W'(1))));

    always_comb begin
        busy_d    = busy_q;
        issuing_d = issuing_q;
        cnt_d     = cnt_q;
        vl_d      = vl_q;
        j_d       = j_q;
        mode_d    = mode_q;
        if (accept) begin
            busy_d    = 1'b1;
            issuing_d = (i_vl != '0);
            cnt_d     = '0;
            vl_d      = i_vl;
            j_d       = i_j;
            mode_d    = mode_e'(i_mode);
        end else begin
            if (done) begin
                busy_d = 1'b0;
            end
            if (issuing_q) begin
                cnt_d = cnt_q + VL_W'(1);
                if (cnt_q == vl_q - VL_W'(1)) begin
                    issuing_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= 1'b0;
            issuing_q  <= 1'b0;
            cnt_q      <= '0;
            vl_q       <= '0;
            j_q        <= '0;
            mode_q     <= MODE_POP;
            in_valid_q <= 1'b0;
            in_idx_q   <= '0;
        end else begin
            busy_q     <= busy_d;
            issuing_q  <= issuing_d;
            cnt_q      <= cnt_d;
            vl_q       <= vl_d;
            j_q        <= j_d;
            mode_q     <= mode_d;
            in_valid_q <= issuing_q;
            in_idx_q   <= cnt_q;
        end
    end

    // Element data shifts left one chunk per stage so each stage reads its chunk from the MSBs.
    always_ff @(posedge clk) begin
        data_pipe[0] <= sel_data;
        for (int s = 1; s < STAGES; s++) begin
            data_pipe[s] <= data_pipe[s-1] << C;
        end
    end

    assign cnt_pipe[0]   = '0;
    assign seen_pipe[0]  = 1'b0;
    assign valid_pipe[0] = in_valid_q;
    assign idx_pipe[0]   = in_idx_q;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        bitcount_stage #(
            .CHUNK (C),
            .CW    (CW),
            .VL_W  (VL_W)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .chunk_i (data_pipe[s][WIDTH-1 -: C]),
            .count_i (cnt_pipe[s]),
            .seen_i  (seen_pipe[s]),
            .valid_i (valid_pipe[s]),
            .idx_i   (idx_pipe[s]),
            .mode_i  (mode_q),
            .count_o (cnt_pipe[s+1]),
            .seen_o  (seen_pipe[s+1]),
            .valid_o (valid_pipe[s+1]),
            .idx_o   (idx_pipe[s+1])
        );
    end

    always_comb begin
        o_result = '0;
        if (valid_pipe[STAGES]) begin
            if (mode_q == MODE_PARITY) begin
                o_result = {{(WIDTH-1){1'b0}}, cnt_pipe[STAGES][0]};
            end else begin
                o_result = WIDTH'(cnt_pipe[STAGES]);
            end
        end
    end

    assign o_valid    = valid_pipe[STAGES];
    assign o_elem_idx = valid_pipe[STAGES] ? idx_pipe[STAGES] : '0;
    assign o_busy     = busy_q;
    assign o_done     = done;

endmodule
